// File: rtl/keccak_pad_stream.sv
// Keccak message padder: turns a byte-granular stream of W-bit lanes into
// whole rate-sized blocks. It appends the mode's domain-separation suffix and
// pad10*1, and adds an extra block when the padding does not fit.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high. A source holds its payload stable while valid is high and ready is
// low. in_ready does not depend on in_valid. out_valid/out_data/out_block_last/
// out_msg_last come straight from registers and are held during stalls.
module keccak_pad_stream #(
    parameter int         W            = 64,
    parameter int         RATE0        = 9,
    parameter int         RATE1        = 17,
    parameter int         RATE2        = 21,
    parameter int         RATE3        = 17,
    parameter logic [7:0] SUFFIX_SHA3  = 8'h06,
    parameter logic [7:0] SUFFIX_SHAKE = 8'h1F,
    parameter int         CW           = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [W-1:0]           in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [$clog2(W/8):0]   in_bytes,
    output logic                   in_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_block_last,
    output logic                   out_msg_last,
    output logic                   busy
);
    localparam int NB = W / 8;
    localparam int BW = $clog2(NB) + 1;

    typedef enum logic [2:0] {S_IDLE, S_DATA, S_SUFX, S_PAD, S_DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] lc;
    logic [CW-1:0] r_last;
    logic [CW-1:0] r_last_sel;
    logic [7:0]    suffix;
    logic          can_load;
    logic          at_end;
    logic          load;
    logic [W-1:0]  lane;
    logic          lane_msg_last;

    assign can_load = ~out_valid | out_ready;
    assign at_end   = (lc == r_last);
    assign in_ready = (state == S_DATA) & can_load;
    assign busy     = (state != S_IDLE);

    // Last lane index of a block for the requested mode.
    always_comb begin
        r_last_sel = CW'(RATE0 - 1);
        case (mode)
            2'd0:    r_last_sel = CW'(RATE0 - 1);
            2'd1:    r_last_sel = CW'(RATE1 - 1);
            2'd2:    r_last_sel = CW'(RATE2 - 1);
            default: r_last_sel = CW'(RATE3 - 1);
        endcase
    end

    // Next state, whether a lane loads this cycle, and what that lane holds.
    always_comb begin
        state_nx      = state;
        load          = 1'b0;
        lane          = '0;
        lane_msg_last = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_DATA;
            end
            S_DATA: begin
                if (in_valid && can_load) begin
                    load = 1'b1;
                    if (!in_last || in_bytes >= BW'(NB)) begin
                        // Ordinary lane, or a full final word: the suffix
                        // then goes into a lane of its own.
                        lane = in_data;
                        if (in_last) state_nx = S_SUFX;
                    end else begin
                        for (int i = 0; i < NB; i++) begin
                            if (BW'(i) < in_bytes)
                                lane[8*i +: 8] = in_data[8*i +: 8];
                            else if (BW'(i) == in_bytes)
                                lane[8*i +: 8] = suffix;
                        end
                        if (at_end) begin
                            lane[W-1 -: 8] = lane[W-1 -: 8] | 8'h80;
                            lane_msg_last  = 1'b1;
                            state_nx       = S_DONE;
                        end else begin
                            state_nx = S_PAD;
                        end
                    end
                end
            end
            S_SUFX: begin
                if (can_load) begin
                    load      = 1'b1;
                    lane[7:0] = suffix;
                    if (at_end) begin
                        lane[W-1 -: 8] = lane[W-1 -: 8] | 8'h80;
                        lane_msg_last  = 1'b1;
                        state_nx       = S_DONE;
                    end else begin
                        state_nx = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (can_load) begin
                    load = 1'b1;
                    if (at_end) begin
                        lane[W-1 -: 8] = 8'h80;
                        lane_msg_last  = 1'b1;
                        state_nx       = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_valid && out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, lane counter, latched mode parameters and the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            lc             <= '0;
            r_last         <= '0;
            suffix         <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_block_last <= 1'b0;
            out_msg_last   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                lc     <= '0;
                r_last <= r_last_sel;
                suffix <= (mode < 2'd2) ? SUFFIX_SHA3 : SUFFIX_SHAKE;
            end else if (load) begin
                lc <= at_end ? '0 : lc + CW'(1);
            end
            if (load) begin
                out_valid      <= 1'b1;
                out_data       <= lane;
                out_block_last <= at_end;
                out_msg_last   <= lane_msg_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // A final word can never claim more bytes than a lane holds.
    a_in_bytes_legal: assert property (@(posedge clk) disable iff (rst)
        (in_valid && in_ready && in_last) |-> (in_bytes <= BW'(NB)));

endmodule

// File: tb/tb_keccak_pad_stream.sv
// Bench for keccak_pad_stream: reference-padded vectors from a table, random
// messages with input gaps and output stalls, and a mid-message reset.
module tb_keccak_pad_stream;
  localparam int W  = 64;
  localparam int NB = W / 8;
  localparam int BW = $clog2(NB) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [BW-1:0] in_bytes = '0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_block_last;
  logic          out_msg_last;
  logic          busy;

  int n_tests = 0;
  int n_fail = 0;
  bit stall_en = 1'b0;

  logic [W-1:0] msg_words[$];
  logic [W-1:0] exp_q[$];
  logic         exp_bl_q[$];
  logic         exp_ml_q[$];
  logic [W-1:0] got_q[$];
  logic         got_bl_q[$];
  logic         got_ml_q[$];

  keccak_pad_stream #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_bytes(in_bytes), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_block_last(out_block_last), .out_msg_last(out_msg_last),
    .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // downstream ready, optionally randomly throttled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // output monitor: records accepted lanes, checks stability during stalls
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_bl, prev_ml;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", {69'(out_data), out_valid, out_block_last, out_msg_last},
                    {69'(prev_data), 1'b1, prev_bl, prev_ml});
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        got_bl_q.push_back(out_block_last);
        got_ml_q.push_back(out_msg_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_bl    = out_block_last;
      prev_ml    = out_msg_last;
    end
  end

  // ---------------- reference model ----------------
  // Message bytes, then suffix, zero fill to a whole number of blocks,
  // then 0x80 ORed into the very last byte.
  function automatic int rate_of(input int m);
    case (m)
      0:       return 9;
      1:       return 17;
      2:       return 21;
      default: return 17;
    endcase
  endfunction

  function automatic void build_exp(input int m, input int k);
    logic [7:0]   b[$];
    logic [W-1:0] l_word;
    int           r, nl, nbyte;
    r = rate_of(m);
    for (int w = 0; w < msg_words.size(); w++) begin
      nbyte = (w == msg_words.size() - 1) ? k : NB;
      for (int i = 0; i < nbyte; i++) b.push_back(msg_words[w][8*i +: 8]);
    end
    b.push_back((m < 2) ? 8'h06 : 8'h1F);
    while ((b.size() % (r * NB)) != 0) b.push_back(8'h00);
    b[b.size() - 1] = b[b.size() - 1] | 8'h80;
    nl = b.size() / NB;
    exp_q.delete(); exp_bl_q.delete(); exp_ml_q.delete();
    for (int l = 0; l < nl; l++) begin
      l_word = '0;
      for (int i = 0; i < NB; i++) l_word[8*i +: 8] = b[l*NB + i];
      exp_q.push_back(l_word);
      exp_bl_q.push_back((l % r) == r - 1);
      exp_ml_q.push_back(l == nl - 1);
    end
  endfunction

  task automatic clear_got();
    got_q.delete(); got_bl_q.delete(); got_ml_q.delete();
  endtask

  task automatic compare_msg(input string tag);
    chk({tag, "_count"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int l = 0; l < got_q.size() && l < exp_q.size(); l++)
      chk($sformatf("%s_lane%0d", tag, l),
          {6'b0, got_bl_q[l], got_ml_q[l], got_q[l]},
          {6'b0, exp_bl_q[l], exp_ml_q[l], exp_q[l]});
  endtask

  // ---------------- driver ----------------
  task automatic run_msg(input int m, input int k, input bit gaps, input string tag);
    int budget;
    bit ok;
    clear_got();
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 2'(m);
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b1;
    for (int w = 0; w < msg_words.size() && ok; w++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = msg_words[w];
      in_last  = (w == msg_words.size() - 1);
      in_bytes = in_last ? BW'(k) : BW'($urandom_range(0, NB));
      budget = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        budget++;
        if (budget > 500) break;
      end
      if (budget > 500) begin
        n_tests++; n_fail++; ok = 1'b0;
        $display("FAIL %s_in_timeout: actual in_ready=0 required in_ready=1", tag);
      end else begin
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
    if (ok) begin
      budget = 0;
      forever begin
        @(negedge clk);
        if (out_valid && out_ready && out_msg_last) break;
        budget++;
        if (budget > 3000) break;
      end
      if (budget > 3000) begin
        n_tests++; n_fail++;
        $display("FAIL %s_out_timeout: actual no msg_last required msg_last", tag);
      end else begin
        chk({tag, "_busy_hi"}, 72'(busy), 72'(1));
        @(posedge clk); #1;
        chk({tag, "_busy_lo"}, 72'(busy), 72'(0));
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           m;
    int           nw;
    int           k;
    logic [W-1:0] fill;
    int           lanes;
    int           idx;
    logic [W-1:0] data;
    logic         bl;
    logic         ml;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{1, 1, 0, 64'hDEADBEEFCAFEF00D, 17, 0,  64'h0000000000000006, 1'b0, 1'b0};
    vecs[1]  = '{1, 1, 0, 64'h5555AAAA5555AAAA, 17, 16, 64'h8000000000000000, 1'b1, 1'b1};
    vecs[2]  = '{2, 3, 3, 64'hFFFFFFFFFFFFFFFF, 21, 2,  64'h000000001FFFFFFF, 1'b0, 1'b0};
    vecs[3]  = '{2, 3, 3, 64'hFFFFFFFFFFFFFFFF, 21, 20, 64'h8000000000000000, 1'b1, 1'b1};
    vecs[4]  = '{0, 9, 8, 64'h0123456789ABCDEF, 18, 8,  64'h0123456789ABCDEF, 1'b1, 1'b0};
    vecs[5]  = '{0, 9, 8, 64'h0123456789ABCDEF, 18, 9,  64'h0000000000000006, 1'b0, 1'b0};
    vecs[6]  = '{0, 9, 8, 64'h0123456789ABCDEF, 18, 17, 64'h8000000000000000, 1'b1, 1'b1};
    vecs[7]  = '{0, 9, 7, 64'hFFFFFFFFFFFFFFFF, 9,  8,  64'h86FFFFFFFFFFFFFF, 1'b1, 1'b1};
    vecs[8]  = '{3, 1, 7, 64'hFFFFFFFFFFFFFFFF, 17, 0,  64'h1FFFFFFFFFFFFFFF, 1'b0, 1'b0};
    vecs[9]  = '{1, 17, 7, 64'hFFFFFFFFFFFFFFFF, 17, 16, 64'h86FFFFFFFFFFFFFF, 1'b1, 1'b1};
    vecs[10] = '{2, 21, 8, 64'hA5A5A5A5A5A5A5A5, 42, 21, 64'h000000000000001F, 1'b0, 1'b0};
    vecs[11] = '{0, 2, 0, 64'h1122334455667788, 9,  1,  64'h0000000000000006, 1'b0, 1'b0};
    vecs[12] = '{0, 1, 4, 64'h0123456789ABCDEF, 9,  0,  64'h0000000689ABCDEF, 1'b0, 1'b0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_out_data", 72'(out_data), 72'(0));
    chk("rst_flags", {70'(out_block_last), out_msg_last, busy}, 72'(0));
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    rst = 1'b0;

    // table-driven vectors
    for (int v = 0; v < NV; v++) begin
      msg_words.delete();
      for (int w = 0; w < vecs[v].nw; w++) msg_words.push_back(vecs[v].fill);
      build_exp(vecs[v].m, vecs[v].k);
      run_msg(vecs[v].m, vecs[v].k, 1'b0, $sformatf("vec%0d", v));
      compare_msg($sformatf("vec%0d_model", v));
      chk($sformatf("vec%0d_lanes", v), 72'(got_q.size()), 72'(vecs[v].lanes));
      if (vecs[v].idx < got_q.size())
        chk($sformatf("vec%0d_lane%0d", v, vecs[v].idx),
            {6'b0, got_bl_q[vecs[v].idx], got_ml_q[vecs[v].idx], got_q[vecs[v].idx]},
            {6'b0, vecs[v].bl, vecs[v].ml, vecs[v].data});
      else begin
        n_tests++; n_fail++;
        $display("FAIL vec%0d_missing_lane: actual %0d lanes required lane %0d",
                 v, got_q.size(), vecs[v].idx);
      end
    end

    // mode 3, 40 words, gaps and stalls
    stall_en = 1'b1;
    msg_words.delete();
    for (int w = 0; w < 40; w++) msg_words.push_back({$urandom, $urandom});
    build_exp(3, 5);
    run_msg(3, 5, 1'b1, "m3_40");
    compare_msg("m3_40_model");
    chk("m3_40_lanes", 72'(got_q.size()), 72'(51));
    if (got_q.size() == 51) begin
      chk("m3_40_bl16", 72'(got_bl_q[16]), 72'(1));
      chk("m3_40_bl33", 72'(got_bl_q[33]), 72'(1));
    end

    // random messages against the model
    for (int t = 0; t < 20; t++) begin
      int m, nw, k;
      m  = $urandom_range(0, 3);
      nw = $urandom_range(1, 45);
      k  = $urandom_range(0, NB);
      msg_words.delete();
      for (int w = 0; w < nw; w++) msg_words.push_back({$urandom, $urandom});
      build_exp(m, k);
      run_msg(m, k, 1'b1, $sformatf("rnd%0d", t));
      compare_msg($sformatf("rnd%0d_model", t));
    end
    stall_en = 1'b0;

    // reset in the middle of a mode-2 message
    clear_got();
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd2;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1; in_last = 1'b0; in_data = {$urandom, $urandom};
    for (int c = 0; c < 200 && got_q.size() < 5; c++) @(negedge clk);
    chk("mid_rst_reached_lane5", 72'(got_q.size() >= 5), 72'(1));
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", 72'(out_valid), 72'(0));
    chk("mid_rst_busy", 72'(busy), 72'(0));
    chk("mid_rst_in_ready", 72'(in_ready), 72'(0));
    clear_got();
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_quiet", {71'(got_q.size()), out_valid}, 72'(0));
    msg_words.delete();
    msg_words.push_back(64'h0123456789ABCDEF);
    build_exp(2, 0);
    run_msg(2, 0, 1'b0, "post_rst");
    compare_msg("post_rst_model");
    chk("post_rst_lanes", 72'(got_q.size()), 72'(21));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/keccak_pad_stream.md
Name: keccak_pad_stream

Overview:
Parametrised successor to the single-lane Keccak padder. Accepts a byte-granular message stream of W-bit lanes over a valid/ready handshake. Emits complete rate-sized blocks of padded lanes for the f_permutation absorb stage. Applies the per-mode domain-separation suffix and pad10*1, masks partial final words, and generates an extra block when padding overflows the current block.

Parameters:
W, 64, lane width in bits; multiple of 8, at least 16
RATE0, 9, lanes per block for mode 0 (SHA3-512)
RATE1, 17, lanes per block for mode 1 (SHA3-256)
RATE2, 21, lanes per block for mode 2 (SHAKE128)
RATE3, 17, lanes per block for mode 3 (SHAKE256)
SUFFIX_SHA3, 8'h06, suffix byte for modes 0 and 1
SUFFIX_SHAKE, 8'h1F, suffix byte for modes 2 and 3
CW, 5, lane counter width; must hold max(RATEn)-1

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  begin a message: latch mode; honoured only in IDLE
mode  in  2  algorithm select; sampled only on an accepted start
in_data  in  W  message lane; byte i is bits [8i+7:8i] (little-endian)
in_valid  in  1  in_data/in_last/in_bytes valid
in_last  in  1  current word is the final message word
in_bytes  in  log2(W/8)+1  valid bytes in the final word, 0..W/8; ignored unless in_last
in_ready  out  1  word accepted when in_valid & in_ready
out_data  out  W  padded lane
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid & out_ready
out_block_last  out  1  out lane is lane RATE-1 of a block
out_msg_last  out  1  out lane is the final lane of the padded message
busy  out  1  high from accepted start until the out_msg_last lane is accepted

Behaviour:
- Reset (sync) values: out_valid=0, out_data=0, out_block_last=0, out_msg_last=0, busy=0, in_ready=0, lane counter=0, FSM=IDLE. Reset asserted mid-message discards all state, including any partial block, with no further output.
- One registered output stage. Data lane appears one cycle after acceptance. in_ready = (state==DATA) & (~out_valid | out_ready).
- Output hold: while out_valid & ~out_ready, out_data, out_block_last and out_msg_last are held stable.
- Lane counter lc counts 0..R-1, where R = RATE[mode latched at start]. It increments on each emitted lane (load of the output register) and wraps to 0 after R-1. out_block_last = (lc == R-1) at load.
- Output formation at each load:
  - data lane: in_data unchanged;
  - last word with k = in_bytes < W/8: bytes 0..k-1 from in_data, byte k = suffix, bytes above k = 0;
  - fill lanes: zero.
  - The pad10*1 end bit applies to whichever lane is loaded with lc == R-1 while in PAD or the last-word transfer: OR 8'h80 into byte W/8-1. Coincident suffix and end bit on the same lane give suffix | 8'h80 (8'h86 or 8'h9F).
- FSM:
  - IDLE: on start, latch mode, lc=0, busy=1, go to DATA. start in any other state is ignored.
  - DATA: each accepted non-last word is emitted as a data lane.
    - Accepted last word with k < W/8: emit the suffixed lane. If lc was R-1, that lane is also the end lane; go to DONE. Otherwise go to PAD.
    - Accepted last word with k = W/8: emit the full data lane, then go to SUFX.
  - SUFX: emit a lane holding only the suffix at byte 0. If it lands at lc = R-1, OR in 8'h80 and go to DONE. Otherwise go to PAD. A full last word at lc = R-1 therefore forces an entire extra block.
  - PAD: emit zero lanes until the lane at lc = R-1, which carries 8'h80 and out_msg_last=1; then go to DONE.
  - DONE: when the out_msg_last lane is accepted, clear busy and go to IDLE. lc is 0 at that point.
- Total emitted lanes is always a nonzero multiple of R. The block never emits a partial block.
- in_bytes=0 with in_last: in_data is ignored; the lane is suffix-only (equivalent to SUFX). An empty message yields exactly one block.
- in_bytes > W/8: illegal; the assertion must fire.

Test Plan:
- mode=1, start, then in_last with in_bytes=0 -> 17 lanes: lane0=64'h06, lanes1..15=0, lane16=64'h8000000000000000 with out_block_last=1 and out_msg_last=1; busy falls the cycle after it is accepted.
- mode=2, 3 words, last word 64'hFFFFFFFFFFFFFFFF with in_bytes=3 -> lane2=64'h000000001FFFFFFF, lanes 3..19=0, lane20=64'h8000000000000000; 21 lanes total.
- mode=0, 9 full words (in_bytes=8 on the 9th) -> 9 data lanes unchanged (lane8 out_block_last=1, out_msg_last=0), then a second block: lane0=64'h06, lanes1..7=0, lane8=64'h8000000000000000 with out_msg_last=1; 18 lanes total.
- mode=0, 9 words, last word all ones with in_bytes=7 -> lane8=64'h86FFFFFFFFFFFFFF with out_msg_last=1; exactly 9 lanes.
- mode=3, 40 words with random in_valid gaps and random out_ready stalls -> data lanes match the input byte-for-byte, with no loss or duplication; out_data stable during stalls; out_block_last on lanes 16 and 33; padded total 51 lanes.
- rst asserted for one cycle at lane 5 of a mode-2 message -> next cycle out_valid=0, busy=0, in_ready=0. A fresh start/empty message then produces a correct 21-lane block beginning at lc=0.
